product_bcd_display: RTL and testbench

//  Consumes the 7-bit product from the 4x3 array multiplier and converts it to 3-digit BCD

---
 rtl/product_bcd_display.sv | 167 ++++++++++++++++
 tb/tb_product_bcd_display.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/product_bcd_display.sv
// product_bcd_display
//   Converts the 7-bit multiplier product to 3-digit BCD with a sequential
//   double-dabble engine and drives a multiplexed 3-digit 7-segment display
//   from the last completed conversion.
// Ports
//   clk     : system clock, rising edge
//   reset   : asynchronous active-high reset
//   product : unsigned product to convert (0..127)
//   load    : start a conversion; only honoured while idle
//   busy    : conversion in progress
//   done    : one-cycle pulse when bcd has just been updated
//   bcd     : {hundreds, tens, ones} of the last completed conversion
//   seg     : active-low segments {g,f,e,d,c,b,a}
//   an      : active-low digit enables, an[0]=ones, an[1]=tens, an[2]=hundreds
module product_bcd_display #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  product,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  bin_q, bin_d;
    logic [11:0] scratch_q, scratch_d;
    logic [2:0]  iter_q, iter_d;
    logic [11:0] bcd_q, bcd_d;
    logic        done_q, done_d;
    logic [11:0] adj;

    logic [CntW-1:0] cnt_q;
    logic [1:0]      idx_q;

    // Add-3 correction on every nibble that is 5 or more, ahead of the shift.
    always_comb begin
        adj = scratch_q;
        for (int n = 0; n < 3; n++) begin
            if (scratch_q[n*4 +: 4] >= 4'd5) begin
                adj[n*4 +: 4] = scratch_q[n*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        iter_d    = iter_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (load) begin
                    bin_d     = product;
                    scratch_d = 12'h000;
                    iter_d    = 3'd0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                {scratch_d, bin_d} = {adj[10:0], bin_q, 1'b0};
                iter_d             = iter_q + 3'd1;
                if (iter_q == 3'd6) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bcd_d   = scratch_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            bin_q     <= 7'd0;
            scratch_q <= 12'h000;
            iter_q    <= 3'd0;
            bcd_q     <= 12'h000;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            iter_q    <= iter_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign bcd  = bcd_q;

    // Display scan: each digit stays lit for REFRESH_DIV cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
        end else if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
            cnt_q <= '0;
            idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    logic [3:0] digit;
    logic       blank;

    always_comb begin
        digit = bcd_q[3:0];
        an    = 3'b110;
        blank = 1'b0;
        case (idx_q)
            2'd1: begin
                digit = bcd_q[7:4];
                an    = 3'b101;
                blank = BLANK_LZ && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
            end
            2'd2: begin
                digit = bcd_q[11:8];
                an    = 3'b011;
                blank = BLANK_LZ && (bcd_q[11:8] == 4'd0);
            end
            default: ;
        endcase
    end

    always_comb begin
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        if (blank) begin
            seg = 7'b1111111;
        end
    end

endmodule

// File: tb/tb_product_bcd_display.sv
module tb_product_bcd_display;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  product = 7'd0;
    logic        load = 1'b0;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  an;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [11:0] bcd_ref = 12'h000;

    product_bcd_display #(
        .REFRESH_DIV(4),
        .BLANK_LZ   (1'b1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .product(product),
        .load   (load),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd),
        .seg    (seg),
        .an     (an)
    );

    always #5 clk = ~clk;

    // Clock edges seen since the last reset; drives the expected scan position.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic convert(input logic [6:0] p, input logic [11:0] exp_b);
        @(negedge clk);
        product = p;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        product = ~p;
        for (int i = 0; i < 8; i++) begin
            chk("busy_during", {31'd0, busy}, 32'd1);
            chk("done_during", {31'd0, done}, 32'd0);
            chk("bcd_hold", {20'd0, bcd}, {20'd0, bcd_ref});
            @(negedge clk);
        end
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("bcd_result", {20'd0, bcd}, {20'd0, exp_b});
        @(negedge clk);
        chk("done_clear", {31'd0, done}, 32'd0);
        bcd_ref = exp_b;
    endtask

    logic [6:0] seg_t3 [3];
    logic [6:0] seg_t6 [3];
    logic [2:0] an_tab [3];

    initial begin
        int dones;
        int idx;
        logic [11:0] e;
        an_tab[0] = 3'b110; an_tab[1] = 3'b101; an_tab[2] = 3'b011;
        seg_t3[0] = 7'b1000000; seg_t3[1] = 7'b1111111; seg_t3[2] = 7'b1111111;
        seg_t6[0] = 7'b1111000; seg_t6[1] = 7'b0100100; seg_t6[2] = 7'b1111001;

        // 1: reset state, then stable while idle
        repeat (2) @(negedge clk);
        chk("rst_bcd", {20'd0, bcd}, 32'h000);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_an", {29'd0, an}, 32'b110);
        chk("rst_seg", {25'd0, seg}, 32'b1000000);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_bcd", {20'd0, bcd}, 32'h000);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_done", {31'd0, done}, 32'd0);
        end

        // 2: 105
        convert(7'd105, 12'h105);

        // 3: zero with leading-zero blanking
        convert(7'd0, 12'h000);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            idx = (cyc / 4) % 3;
            chk("t3_an", {29'd0, an}, {29'd0, an_tab[idx]});
            chk("t3_seg", {25'd0, seg}, {25'd0, seg_t3[idx]});
        end

        // 4: load while busy is ignored
        @(negedge clk);
        product = 7'd105;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        product = 7'd11;
        dones   = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            dones += int'(done);
            if (i == 2) begin
                load    = 1'b1;
                product = 7'd42;
            end
            if (i == 3) load = 1'b0;
            if (i == 8) begin
                chk("t4_done", {31'd0, done}, 32'd1);
                chk("t4_bcd", {20'd0, bcd}, 32'h105);
            end
        end
        chk("t4_single_done", dones, 32'd1);
        chk("t4_bcd_final", {20'd0, bcd}, 32'h105);
        bcd_ref = 12'h105;

        // 5: reset mid-conversion
        @(negedge clk);
        product = 7'd99;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_bcd", {20'd0, bcd}, 32'h000);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_an", {29'd0, an}, 32'b110);
        chk("t5_seg", {25'd0, seg}, 32'b1000000);
        @(negedge clk);
        reset   = 1'b0;
        bcd_ref = 12'h000;
        convert(7'd99, 12'h099);

        // 6: scan of 127 with REFRESH_DIV=4
        convert(7'd127, 12'h127);
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            idx = (cyc / 4) % 3;
            chk("t6_an", {29'd0, an}, {29'd0, an_tab[idx]});
            chk("t6_seg", {25'd0, seg}, {25'd0, seg_t6[idx]});
        end

        // Sweep all inputs
        for (int p = 0; p < 128; p++) begin
            e = {4'(p / 100), 4'((p / 10) % 10), 4'(p % 10)};
            convert(7'(p), e);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
